// File: rtl/pwm_dec_pkg.sv
// Shared types and constants for the PWM duty decoder: FSM state encoding,
// default sizing and the deglitch filter length.
package pwm_dec_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam int DEF_CNT_W       = 16;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEGLITCH_LEN    = 3;

endpackage

// File: rtl/pwm_in_cond.sv
// Input conditioning for the PWM decoder: synchronizer, optional stability
// filter (PWM_DEC_DEGLITCH_EN) and rising-edge detector.
module pwm_in_cond
    import pwm_dec_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk1,
    input  logic rst,
    input  logic pwm_in,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic                   prev_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

`ifdef PWM_DEC_DEGLITCH_EN
    logic [DEGLITCH_LEN-2:0] hist_q;
    logic                    filt_q;
    logic                    all_high;
    logic                    all_low;

    // Level follows synced only once the current and previous two samples agree.
    assign all_high = &{synced, hist_q};
    assign all_low  = ~|{synced, hist_q};
    assign level    = (all_high || all_low) ? synced : filt_q;

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
            filt_q <= 1'b0;
        end else begin
            hist_q <= {hist_q[DEGLITCH_LEN-3:0], synced};
            filt_q <= level;
        end
    end
`else
    assign level = synced;
`endif

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level;
        end
    end

    assign rise = level & ~prev_q;

endmodule

// File: rtl/pwm_duty_decoder.sv
// PWM duty decoder top: frame FSM, high/period counters, valid/ready output
// register with overrun and timeout flags. Optional filter: PWM_DEC_DEGLITCH_EN.
module pwm_duty_decoder
    import pwm_dec_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk1,
    input  logic             rst,
    input  logic             pwm_in,
    input  logic             sample_ready,
    output logic             sample_valid,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             overrun,
    output logic             timeout,
    output logic             stuck_level
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             level;
    logic             rise;
    state_t           state, state_nx;
    logic [CNT_W-1:0] period, period_nx;
    logic [CNT_W-1:0] high, high_nx;
    logic             capture;
    logic             expire;
    logic             drop;
    logic             handshake;

    pwm_in_cond #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_cond (
        .clk1  (clk1),
        .rst   (rst),
        .pwm_in(pwm_in),
        .level (level),
        .rise  (rise)
    );

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_nx  = state;
        period_nx = period;
        high_nx   = high;
        capture   = 1'b0;
        expire    = 1'b0;
        unique case (state)
            IDLE: begin
                if (rise) begin
                    state_nx  = MEASURE;
                    period_nx = CNT_ONE;
                    high_nx   = CNT_ONE;
                end
            end
            MEASURE: begin
                if (rise) begin
                    capture   = 1'b1;
                    period_nx = CNT_ONE;
                    high_nx   = CNT_ONE;
                end else if (period == CNT_MAX) begin
                    // No edge in range: drop the partial frame before the counter can wrap.
                    expire    = 1'b1;
                    state_nx  = IDLE;
                    period_nx = '0;
                    high_nx   = '0;
                end else begin
                    period_nx = period + CNT_ONE;
                    high_nx   = high + CNT_W'(level);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            period <= '0;
            high   <= '0;
        end else begin
            state  <= state_nx;
            period <= period_nx;
            high   <= high_nx;
        end
    end

    assign handshake = sample_valid & sample_ready;
    assign drop      = capture & sample_valid & ~sample_ready;

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            sample_valid <= 1'b0;
            high_cnt     <= '0;
            period_cnt   <= '0;
            overrun      <= 1'b0;
            timeout      <= 1'b0;
            stuck_level  <= 1'b0;
        end else begin
            if (capture && !drop) begin
                high_cnt     <= high;
                period_cnt   <= period;
                sample_valid <= 1'b1;
            end else if (handshake) begin
                sample_valid <= 1'b0;
            end
            if (drop) begin
                overrun <= 1'b1;
            end else if (handshake) begin
                overrun <= 1'b0;
            end
            timeout <= expire;
            if (expire) begin
                stuck_level <= level;
            end
        end
    end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Self-checking bench for pwm_duty_decoder (CNT_W=8): table vectors, corner
// sequences and randomized frames against a pin-level frame model.
module tb_pwm_duty_decoder;

    localparam int CNT_W = 8;
    localparam int SYNC  = 2;
    localparam int HOLD  = (1 << CNT_W) + 20;

    logic             clk1 = 1'b0;
    logic             rst = 1'b1;
    logic             pwm_in = 1'b0;
    logic             sample_ready = 1'b0;
    logic             sample_valid;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] period_cnt;
    logic             overrun;
    logic             timeout;
    logic             stuck_level;

    pwm_duty_decoder #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk1        (clk1),
        .rst         (rst),
        .pwm_in      (pwm_in),
        .sample_ready(sample_ready),
        .sample_valid(sample_valid),
        .high_cnt    (high_cnt),
        .period_cnt  (period_cnt),
        .overrun     (overrun),
        .timeout     (timeout),
        .stuck_level (stuck_level)
    );

    always #5 clk1 = ~clk1;

    typedef struct packed {
        logic [CNT_W-1:0] h;
        logic [CNT_W-1:0] p;
    } frame_t;

    typedef struct {
        int h;
        int p;
        int frames;
        int exp_high;
        int exp_period;
        int exp_samples;
    } vec_t;

    frame_t got[$];
    frame_t exp_q[$];
    bit     hist[$];
    int     to_cnt = 0;
    int     inv_err = 0;
    int     n_tests = 0;
    int     n_fail = 0;

    // Accepted samples, timeout pulses and the high<=period invariant.
    always @(negedge clk1) begin
        if (!rst) begin
            if (sample_valid && sample_ready) got.push_back('{h: high_cnt, p: period_cnt});
            if (timeout) to_cnt++;
            if (sample_valid && (high_cnt > period_cnt)) inv_err++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic drive(input bit v);
        step();
        pwm_in = v;
        hist.push_back(v);
    endtask

    task automatic drive_frame(input int h, input int p);
        for (int i = 0; i < p; i++) drive(i < h);
    endtask

    task automatic do_reset(input bit rdy);
        rst = 1'b1;
        pwm_in = 1'b0;
        sample_ready = rdy;
        repeat (3) step();
        rst = 1'b0;
        hist.delete();
        got.delete();
        to_cnt = 0;
    endtask

    // Reference: frames are the spans between rising edges of the (optionally
    // filtered) pin level; period is the span length, high the count of ones in it.
    task automatic build_expected();
        bit     f, fp;
        int     last_rise, ones;
        frame_t fr;
        exp_q.delete();
        fp = 1'b0;
        last_rise = -1;
        ones = 0;
        for (int i = 0; i < hist.size(); i++) begin
`ifdef PWM_DEC_DEGLITCH_EN
            f = (i >= 2 && hist[i] == hist[i-1] && hist[i-1] == hist[i-2]) ? hist[i] : fp;
`else
            f = hist[i];
`endif
            if (f && !fp) begin
                if (last_rise >= 0) begin
                    fr.h = CNT_W'(ones);
                    fr.p = CNT_W'(i - last_rise);
                    exp_q.push_back(fr);
                end
                last_rise = i;
                ones = 0;
            end
            if (f) ones++;
            fp = f;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s_high[%0d]", tag, i), got[i].h, exp_q[i].h);
            check($sformatf("%s_period[%0d]", tag, i), got[i].p, exp_q[i].p);
        end
    endtask

    initial begin
        vec_t vecs[6];
        int   k;
        bit   found;
        int   n_mark;

        vecs[0] = '{h: 3,  p: 10, frames: 6, exp_high: 3,  exp_period: 10, exp_samples: 6};
        vecs[1] = '{h: 5,  p: 20, frames: 3, exp_high: 5,  exp_period: 20, exp_samples: 3};
        vecs[2] = '{h: 4,  p: 16, frames: 4, exp_high: 4,  exp_period: 16, exp_samples: 4};
        vecs[3] = '{h: 10, p: 13, frames: 3, exp_high: 10, exp_period: 13, exp_samples: 3};
        vecs[4] = '{h: 3,  p: 6,  frames: 5, exp_high: 3,  exp_period: 6,  exp_samples: 5};
        vecs[5] = '{h: 30, p: 40, frames: 2, exp_high: 30, exp_period: 40, exp_samples: 2};

        // Reset state
        do_reset(1'b1);
        @(negedge clk1);
        check("rst_valid", sample_valid, 0);
        check("rst_high", high_cnt, 0);
        check("rst_period", period_cnt, 0);
        check("rst_overrun", overrun, 0);
        check("rst_timeout", timeout, 0);
        check("rst_stuck", stuck_level, 0);

        // Steady PWM vectors
        for (int v = 0; v < 6; v++) begin
            do_reset(1'b1);
            repeat (vecs[v].frames + 1) drive_frame(vecs[v].h, vecs[v].p);
            repeat (10) drive(1'b0);
            check($sformatf("vec%0d_count", v), got.size(), vecs[v].exp_samples);
            for (int i = 0; i < got.size(); i++) begin
                check($sformatf("vec%0d_high[%0d]", v, i), got[i].h, vecs[v].exp_high);
                check($sformatf("vec%0d_period[%0d]", v, i), got[i].p, vecs[v].exp_period);
            end
            check($sformatf("vec%0d_overrun", v), overrun, 0);
            check($sformatf("vec%0d_no_timeout", v), to_cnt, 0);
        end

        // Timeout at both stuck levels, then normal measurement resumes
        do_reset(1'b1);
        for (int lv = 1; lv >= 0; lv--) begin
            drive_frame(3, 10);
            drive_frame(3, 10);
            to_cnt = 0;
            repeat (10) drive(lv[0]);
            n_mark = got.size();
            repeat (HOLD - 10) drive(lv[0]);
            check($sformatf("to%0d_pulses", lv), to_cnt, 1);
            check($sformatf("to%0d_no_sample", lv), got.size(), n_mark);
            check($sformatf("to%0d_stuck", lv), stuck_level, lv);
            check($sformatf("to%0d_pulse_ended", lv), timeout, 0);
            repeat (3) drive(1'b0);
            hist.delete();
            got.delete();
            repeat (3) drive_frame(4, 12);
            repeat (10) drive(1'b0);
            build_expected();
            compare_all($sformatf("after_to%0d", lv));
        end

        // Overrun: consumer stalls across two completed frames
        do_reset(1'b0);
        drive_frame(3, 10);
        drive_frame(5, 12);
        drive_frame(4, 9);
        repeat (5) drive(1'b0);
        @(negedge clk1);
        check("ovr_valid_held", sample_valid, 1);
        check("ovr_high_kept", high_cnt, 3);
        check("ovr_period_kept", period_cnt, 10);
        check("ovr_flag", overrun, 1);
        step();
        sample_ready = 1'b1;
        step();
        sample_ready = 1'b0;
        @(negedge clk1);
        check("ovr_valid_cleared", sample_valid, 0);
        check("ovr_flag_cleared", overrun, 0);

        // Locate the capture cycle relative to the pin rise of the closing frame
        do_reset(1'b1);
        drive_frame(3, 10);
        found = 1'b0;
        k = 0;
        for (int i = 0; i < 10; i++) begin
            drive(i < 3);
            if (!found) begin
                @(negedge clk1);
                if (sample_valid) begin
                    found = 1'b1;
                    k = i;
                end
            end
        end
        check("capture_latency_found", found, 1);

        // Capture coincident with a handshake of the pending sample
        if (found && k >= 1) begin
            do_reset(1'b0);
            drive_frame(3, 10);
            drive_frame(5, 12);
            for (int i = 0; i <= k; i++) begin
                drive(i < 4);
                sample_ready = (i == k - 1);
            end
            @(negedge clk1);
            check("coin_valid", sample_valid, 1);
            check("coin_high", high_cnt, 5);
            check("coin_period", period_cnt, 12);
            check("coin_overrun", overrun, 0);
            check("coin_accepted", got.size(), 1);
            if (got.size() > 0) begin
                check("coin_old_high", got[0].h, 3);
                check("coin_old_period", got[0].p, 10);
            end
        end

        // Reset mid-frame
        do_reset(1'b1);
        drive_frame(5, 20);
        for (int i = 0; i < 8; i++) drive(i < 5);
        check("mid_pre_high", high_cnt, 5);
        rst = 1'b1;
        #1;
        check("mid_valid", sample_valid, 0);
        check("mid_high", high_cnt, 0);
        check("mid_period", period_cnt, 0);
        check("mid_flags", {overrun, timeout, stuck_level}, 0);
        repeat (2) step();
        rst = 1'b0;
        hist.delete();
        got.delete();
        repeat (12) drive(1'b0);
        drive_frame(5, 20);
        check("mid_one_edge_no_sample", got.size(), 0);
        drive_frame(5, 20);
        check("mid_samples", got.size(), 1);
        if (got.size() > 0) begin
            check("mid_first_high", got[0].h, 5);
            check("mid_first_period", got[0].p, 20);
        end

        // Two-cycle glitch in the low phase of H=4, P=16
        do_reset(1'b1);
        repeat (3) begin
            for (int i = 0; i < 16; i++) drive(i < 4 || i == 8 || i == 9);
        end
        drive_frame(4, 14);
`ifdef PWM_DEC_DEGLITCH_EN
        check("glitch_count", got.size(), 3);
        for (int i = 0; i < got.size(); i++) begin
            check($sformatf("glitch_high[%0d]", i), got[i].h, 4);
            check($sformatf("glitch_period[%0d]", i), got[i].p, 16);
        end
`else
        check("glitch_count", got.size(), 6);
        for (int i = 0; i < got.size(); i++) begin
            check($sformatf("glitch_high[%0d]", i), got[i].h, (i % 2 == 0) ? 4 : 2);
            check($sformatf("glitch_period[%0d]", i), got[i].p, 8);
        end
`endif

        // Randomized frames with a consumer that stalls at most two cycles
        do_reset(1'b1);
        begin
            bit rnd_active;
            rnd_active = 1'b1;
            fork
                begin
                    for (int f = 0; f < 40; f++) begin
                        int h, lo;
                        h  = $urandom_range(3, 20);
                        lo = $urandom_range(3, 20);
                        drive_frame(h, h + lo);
                    end
                    drive_frame(4, 14);
                    rnd_active = 1'b0;
                end
                begin
                    int lowrun;
                    lowrun = 0;
                    while (rnd_active) begin
                        step();
                        if (lowrun < 2 && $urandom_range(0, 2) == 0) begin
                            sample_ready = 1'b0;
                            lowrun++;
                        end else begin
                            sample_ready = 1'b1;
                            lowrun = 0;
                        end
                    end
                end
            join
        end
        sample_ready = 1'b1;
        repeat (5) drive(1'b0);
        build_expected();
        compare_all("rnd");
        check("rnd_overrun", overrun, 0);
        check("rnd_no_timeout", to_cnt, 0);
        check("high_le_period", inv_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_duty_decoder.md
# pwm_duty_decoder

Measures the high time and period of an incoming single-bit PWM stream, one frame at a time, and delivers each frame as a sample on a valid/ready interface. It is the receive-side counterpart of the sine PWM generator: it sits on a loopback or external input pin and turns pulse widths back into numeric duty samples. The sine output can then be checked on-chip or forwarded over UART.

## Interface
Parameters:
- CNT_W, 16, width of the high-time and period counters and sample fields (8..24)
- SYNC_STAGES, 2, flops in the input synchronizer (2..3)

Ports:
- clk1  in  1  sole clock
- rst  in  1  reset, asynchronous, active-high
- pwm_in  in  1  asynchronous PWM input
- sample_ready  in  1  consumer accepts the sample this cycle
- sample_valid  out  1  sample held on high_cnt/period_cnt
- high_cnt  out  CNT_W  clk1 cycles the input was high in the frame
- period_cnt  out  CNT_W  clk1 cycles from one rising edge to the next
- overrun  out  1  sticky: a completed frame was dropped because the output was occupied
- timeout  out  1  one-cycle pulse: no rising edge within 2^CNT_W−1 cycles
- stuck_level  out  1  synchronized input level captured at the last timeout

## Operation
- The input passes through SYNC_STAGES flops, then one edge register. `rise` = synced & ~prev.
- FSM states are IDLE, MEASURE.
  - IDLE: wait for `rise`. On `rise`, go to MEASURE, set period=1 and high=1.
  - MEASURE: each cycle, period+=1 and high+=synced.
  - On `rise` in MEASURE, the frame completes. Capture {high, period} excluding the current cycle, then restart both counters at 1.
- For a steady input with H high cycles and period P: high_cnt=H, period_cnt=P.
- Timeout: when period reaches 2^CNT_W−1 without a `rise`:
  - pulse timeout for one cycle;
  - latch stuck_level = synced;
  - go to IDLE;
  - discard the partial frame.
  - This covers 0% and 100% duty.
- Output register:
  - A capture loads high_cnt/period_cnt and sets sample_valid.
  - sample_valid&sample_ready clears sample_valid.
  - Capture while sample_valid=1 and sample_ready=0: the new frame is dropped, the old sample is kept, and overrun is set.
  - Capture and handshake in the same cycle: the new sample loads, sample_valid stays 1, and there is no overrun.
- overrun clears on the next accepted handshake after it was set, unless a new drop happens in that same cycle.
- The first frame after reset or timeout is measured normally; the IDLE→MEASURE edge starts it.

## Timing
- Reset values: sample_valid=0, high_cnt=0, period_cnt=0, overrun=0, timeout=0, stuck_level=0, FSM=IDLE, sync chain=0.
- Latency from pin edge to `rise` is SYNC_STAGES+1 cycles. sample_valid rises one cycle after the capturing `rise`.
- Assertion of rst mid-frame clears state immediately. The first sample after deassertion requires two rising edges.
- high_cnt ≤ period_cnt always. Counters never wrap, because timeout precedes overflow.
- Outputs are registered, with no combinational path from sample_ready to any output.

## Configuration
- PWM_DEC_DEGLITCH_EN defined:
  - A 3-cycle stability filter follows the synchronizer. The filtered level changes only after 3 consecutive equal synced samples.
  - Input-to-`rise` latency becomes SYNC_STAGES+3.
  - Pulses shorter than 3 cycles are ignored.
- PWM_DEC_DEGLITCH_EN undefined:
  - No filter; the synced level is used directly.

## Structure
- Shared package pwm_dec_pkg holds:
  - the FSM state typedef (IDLE, MEASURE);
  - default CNT_W and SYNC_STAGES constants;
  - the deglitch length constant (3).
- Sub-module pwm_in_cond contains the synchronizer, the optional deglitch filter and the edge detector. Its outputs are level and rise.
- The top contains the FSM, counters, output register and flags.

## Test plan
- Steady PWM with H=3, P=10, sample_ready=1, six frames. Expect from the second sample on: high_cnt=3, period_cnt=10, one sample_valid pulse per frame, overrun=0.
- pwm_in held 0 for 2^CNT_W+20 cycles, with CNT_W=8. Expect a single timeout pulse, stuck_level=0, no sample. Repeat with the input held at 1: stuck_level=1.
- sample_ready=0 across two completed frames. Expect the first sample to be held and overrun=1. A later handshake clears sample_valid and overrun.
- Capture coincident with a sample_valid&sample_ready handshake. Expect the new sample to load, sample_valid to stay 1 and overrun=0.
- rst pulse mid-frame (H=5, P=20). Expect all outputs 0 immediately. After release, the first sample arrives only after two rising edges and has high_cnt=5, period_cnt=20.
- With PWM_DEC_DEGLITCH_EN, a 2-cycle glitch inside the low phase of H=4, P=16. Expect it ignored: high_cnt=4, period_cnt=16. Without the macro, the same glitch splits the frame.
